// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator: channel count, stage limit and channel select type.
// The comb stage imports this package as well.
package cic_pkg;

  localparam int CIC_NUM_CH     = 4;
  localparam int CIC_MAX_STAGES = 5;

  typedef logic [1:0] cic_sel_t;

endpackage

// File: rtl/cic_integ_bank.sv
// Per-channel integrator chains for the CIC front half.
// Only the selected channel advances; "last" is that channel's last stage after this edge's update.
module cic_integ_bank
  import cic_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  cic_sel_t         sel,
  input  logic             x,
  output logic [WIDTH-1:0] last
);

  logic [WIDTH-1:0]                  x_ext;
  logic [CIC_NUM_CH-1:0][WIDTH-1:0] ch_last;

  // PDM 1 -> +1, PDM 0 -> -1 in two's complement
  assign x_ext = x ? WIDTH'(1) : '1;

  for (genvar gi = 0; gi < CIC_NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] stage_reg [STAGES];
    logic             hit;

    assign hit = en && (sel == cic_sel_t'(gi));

    // Every stage adds its predecessor's pre-edge value: one sample of delay per stage.
    always_ff @(posedge clk) begin
      if (clr) begin
        for (int k = 0; k < STAGES; k++) stage_reg[k] <= '0;
      end else if (hit) begin
        stage_reg[0] <= stage_reg[0] + x_ext;
        for (int k = 1; k < STAGES; k++) stage_reg[k] <= stage_reg[k] + stage_reg[k-1];
      end
    end

    if (STAGES == 1) begin : g_one
      assign ch_last[gi] = stage_reg[0] + x_ext;
    end else begin : g_multi
      assign ch_last[gi] = stage_reg[STAGES-1] + stage_reg[STAGES-2];
    end
  end

  assign last = ch_last[sel];

endmodule

// File: rtl/cic_integrator_decim.sv
// CIC integrator + decimator: four time-multiplexed PDM channels, one WIDTH-bit strobe
// per decim_i+1 samples of a channel, driving the comb stage directly.
module cic_integrator_decim
  import cic_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int STAGES  = 5,
  parameter int DECIM_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [1:0]         sel_i,
  input  logic               data_i,
  input  logic [DECIM_W-1:0] decim_i,
  output logic               valid_o,
  output logic [1:0]         sel_o,
  output logic [WIDTH-1:0]   data_o
);

  logic [DECIM_W-1:0] cnt_reg [CIC_NUM_CH];
  logic               valid_reg;
  logic [1:0]         sel_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [WIDTH-1:0]   last;
  logic               bank_clr;
  logic               fire;

  assign bank_clr = rst_i | clr_i;

  cic_integ_bank #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_bank (
    .clk  (clk_i),
    .clr  (bank_clr),
    .en   (en_i),
    .sel  (cic_sel_t'(sel_i)),
    .x    (data_i),
    .last (last)
  );

  // >= so a count already past a newly lowered ratio fires instead of running away
  assign fire = en_i && (cnt_reg[sel_i] >= decim_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int c = 0; c < CIC_NUM_CH; c++) cnt_reg[c] <= '0;
      valid_reg <= 1'b0;
      sel_reg   <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg <= fire;
      if (en_i) begin
        if (fire) cnt_reg[sel_i] <= '0;
        else      cnt_reg[sel_i] <= cnt_reg[sel_i] + DECIM_W'(1);
      end
      if (fire) begin
        sel_reg  <= sel_i;
        data_reg <= last;
      end
    end
  end

  assign valid_o = valid_reg;
  assign sel_o   = sel_reg;
  assign data_o  = data_reg;

endmodule

// File: tb/tb_cic_integrator_decim.sv
// Directed bench for cic_integrator_decim: three instances (1 stage, 2 stages, 8-bit wrap)
// share stimulus; a reference model queues expected outputs, popped and checked each cycle.
module tb_cic_integrator_decim;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  sel = '0;
  logic        data = 1'b0;
  logic [9:0]  decim = '0;

  logic        valid_a, valid_b, valid_c;
  logic [1:0]  sel_a, sel_b, sel_c;
  logic [63:0] data_a, data_b;
  logic [7:0]  data_c;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cic_integrator_decim #(.WIDTH(64), .STAGES(1), .DECIM_W(10)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .sel_i(sel), .data_i(data),
    .decim_i(decim), .valid_o(valid_a), .sel_o(sel_a), .data_o(data_a));

  cic_integrator_decim #(.WIDTH(64), .STAGES(2), .DECIM_W(10)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .sel_i(sel), .data_i(data),
    .decim_i(decim), .valid_o(valid_b), .sel_o(sel_b), .data_o(data_b));

  cic_integrator_decim #(.WIDTH(8), .STAGES(1), .DECIM_W(10)) dut_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .sel_i(sel), .data_i(data),
    .decim_i(decim), .valid_o(valid_c), .sel_o(sel_c), .data_o(data_c));

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic [63:0] a;
    logic [63:0] b;
    logic [7:0]  c;
  } exp_t;

  exp_t q[$];

  // Reference state: two integrator stages per channel cover both STAGES=1 and STAGES=2.
  logic [63:0] m_int [4][2];
  logic [9:0]  m_cnt [4];
  logic [1:0]  h_sel = '0;
  logic [63:0] h_a = '0;
  logic [63:0] h_b = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input logic r, input logic e, input logic cl, input logic [1:0] s,
                       input logic d);
    exp_t        ex;
    logic        fire;
    logic [63:0] n0, n1;
    fire = 1'b0;
    if (r || cl) begin
      for (int c = 0; c < 4; c++) begin
        m_int[c][0] = '0;
        m_int[c][1] = '0;
        m_cnt[c]    = '0;
      end
      h_sel = '0;
      h_a   = '0;
      h_b   = '0;
    end else if (e) begin
      n0 = m_int[s][0] + (d ? 64'd1 : 64'hFFFF_FFFF_FFFF_FFFF);
      n1 = m_int[s][1] + m_int[s][0];
      m_int[s][0] = n0;
      m_int[s][1] = n1;
      if (m_cnt[s] >= decim) begin
        m_cnt[s] = '0;
        fire = 1'b1;
        h_sel = s;
        h_a = n0;
        h_b = n1;
      end else begin
        m_cnt[s] = m_cnt[s] + 10'd1;
      end
    end
    ex.v = fire;
    ex.s = h_sel;
    ex.a = h_a;
    ex.b = h_b;
    ex.c = h_a[7:0];
    q.push_back(ex);
  endtask

  task automatic step(input logic r, input logic e, input logic cl, input logic [1:0] s,
                      input logic d);
    exp_t ex;
    rst = r; en = e; clr = cl; sel = s; data = d;
    model(r, e, cl, s, d);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk("valid_a", 64'(valid_a), 64'(ex.v));
    chk("valid_b", 64'(valid_b), 64'(ex.v));
    chk("valid_c", 64'(valid_c), 64'(ex.v));
    chk("sel_a", 64'(sel_a), 64'(ex.s));
    chk("sel_b", 64'(sel_b), 64'(ex.s));
    chk("sel_c", 64'(sel_c), 64'(ex.s));
    chk("data_a", data_a, ex.a);
    chk("data_b", data_b, ex.b);
    chk("data_c", 64'(data_c), 64'(ex.c));
    if (valid_a)
      $display("out t=%0t sel=%0d a=%0h b=%0h c=%0h", $time, sel_a, data_a, data_b, data_c);
    rst = 1'b0; en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      m_int[c][0] = '0;
      m_int[c][1] = '0;
      m_cnt[c]    = '0;
    end

    // Reset state
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_data", data_a, 64'd0);

    // Constant ones on ch0, decim 3
    decim = 10'd3;
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
      if (n == 3) chk("t1_nofire3", 64'(valid_a), 64'd0);
      if (n == 4) begin
        chk("t1_a4", data_a, 64'd4);
        chk("t1_b4", data_b, 64'd6);
      end
      if (n == 8) begin
        chk("t1_a8", data_a, 64'd8);
        chk("t1_b8", data_b, 64'd28);
      end
      if (n == 12) chk("t1_a12", data_a, 64'd12);
    end

    // Interleaved ch0 ones / ch1 zeros, decim 1
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    decim = 10'd1;
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 1'b1, 1'b0, (n % 2 == 1) ? 2'd0 : 2'd1, (n % 2 == 1));
      if (n == 3) chk("il_ch0", data_a, 64'd2);
      if (n == 4) chk("il_ch1", data_a, 64'hFFFF_FFFF_FFFF_FFFE);
      if (n == 8) chk("il_ch1b", data_a, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    // Channel 2 was never touched: its first sample integrates from zero
    decim = 10'd0;
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b1);
    chk("il_ch2", data_a, 64'd1);

    // 8-bit wrap, decim 0, 129 ones
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int n = 1; n <= 129; n++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
      if (n == 127) chk("wrap127", 64'(data_c), 64'h7F);
      if (n == 128) chk("wrap128", 64'(data_c), 64'h80);
      if (n == 129) chk("wrap129", 64'(data_c), 64'h81);
    end

    // Clear together with a sample mid-decimation
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    decim = 10'd3;
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    chk("clr_valid", 64'(valid_a), 64'd0);
    for (int n = 1; n <= 4; n++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
      if (n == 3) chk("clr_nofire", 64'(valid_a), 64'd0);
      if (n == 4) chk("clr_out", data_a, 64'd4);
    end

    // Reset while valid_o is high, then shrink decim mid-count
    decim = 10'd0;
    step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
    chk("pre_rst_valid", 64'(valid_a), 64'd1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_valid", 64'(valid_a), 64'd0);
    chk("post_rst_sel", 64'(sel_a), 64'd0);
    chk("post_rst_data", data_a, 64'd0);
    decim = 10'd7;
    for (int n = 1; n <= 5; n++) step(1'b0, 1'b1, 1'b0, 2'd3, 1'b1);
    decim = 10'd1;
    step(1'b0, 1'b1, 1'b0, 2'd3, 1'b1);
    chk("shrink_valid", 64'(valid_a), 64'd1);
    chk("shrink_sel", 64'(sel_a), 64'd3);
    chk("shrink_data", data_a, 64'd6);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("single_cycle", 64'(valid_a), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cic_integrator_decim.md
# cic_integrator_decim

Integrator-and-decimation front half of the PDM-to-PCM CIC filter in the uDMA I2S/PDM receive path. Accepts 1-bit PDM samples for up to four time-multiplexed channels, runs a STAGES-deep integrator chain per channel, and counts samples per channel. Every decim_i+1 samples of a channel it emits one WIDTH-bit integrated value, tagged with that channel, as a single-cycle strobe to the downstream comb stage, whose en/sel/data inputs it drives directly.

## Interface
- WIDTH, 64: integrator/output width; modulo-2^WIDTH arithmetic
- STAGES, 5: integrator stages per channel, 1..5
- DECIM_W, 10: width of the decimation-ratio input
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- en_i  in  1  input sample valid for channel sel_i
- clr_i  in  1  synchronous clear of all state
- sel_i  in  2  channel of the current input sample
- data_i  in  1  PDM bit; 1 maps to +1, 0 maps to −1 (sign-extended to WIDTH)
- decim_i  in  DECIM_W  decimation ratio minus 1; quasi-static
- valid_o  out  1  one-cycle output strobe
- sel_o  out  2  channel of data_o
- data_o  out  WIDTH  last-stage integrator value of channel sel_o

## Operation
- State per channel c (4 channels): integ[c][0..STAGES-1] (WIDTH each) and cnt[c] (DECIM_W).
- On en_i with sel_i=c, all stages of channel c update in the same edge from pre-edge values:
  - integ[c][0] += x, where x = ±1
  - integ[c][k] += integ[c][k−1]_old for k ≥ 1
  - This gives one sample of delay per stage, which is intended.
- Decimation on the same edge:
  - If cnt[c] ≥ decim_i: cnt[c] ← 0 and an output is fired.
  - Otherwise cnt[c] ← cnt[c]+1.
  - ≥ rather than == prevents a run-away count when decim_i shrinks mid-run.
- Output fire: valid_o ← 1, sel_o ← c, data_o ← the updated integ[c][STAGES−1] (post-edge value).
- When no fire occurs: valid_o ← 0; sel_o and data_o hold their values.
- Channels not selected are untouched.
- All adds wrap modulo 2^WIDTH with no saturation. CIC wrap is benign because the comb stage wraps identically. Choosing WIDTH ≥ STAGES·log2(R)+1 is software's responsibility.
- No backpressure: the consumer must accept every strobe.

## Timing
- Reset (rst_i=1) and clr_i=1: all integ, all cnt, valid_o, sel_o and data_o go to 0 on the next edge.
- Priority is rst_i > clr_i > en_i. If clr_i and en_i are high together, the sample is dropped.
- Latency: input edge to valid_o high is 1 cycle. valid_o is high for exactly one cycle per fire.
- Back-to-back en_i every cycle is supported, including on the same channel. Consecutive fires from different channels produce consecutive valid_o cycles.
- A reset or clear mid-decimation discards partial counts. The first output after it needs a full decim_i+1 samples.
- decim_i=0 fires on every sample.

## Structure
- Shared package cic_pkg:
  - CIC_NUM_CH=4
  - channel select type (2-bit)
  - constant CIC_MAX_STAGES=5
  - The comb stage reuses this package.
- One sub-module, cic_integ_bank: holds the 4×STAGES register array and performs the chained add for the selected channel. It takes en, clr, sel and x, and returns the post-update last-stage value.
- The top level holds the per-channel counters, fire logic and output registers.

## Test plan
- Constant ones, STAGES=1, decim_i=3, ch0, en_i every cycle:
  - valid_o on every 4th sample, 1 cycle after the 4th input edge
  - data_o = 4, 8, 12; sel_o = 0
- Constant ones, STAGES=2, decim_i=3: data_o = 6 then 28, i.e. n(n−1)/2 at n=4 and n=8.
- Interleave, STAGES=1, decim_i=1: ch0 gets all ones and ch1 all zeros, alternating on sel_i every cycle.
  - Outputs (sel_o=0, 2), (sel_o=1, −2 = all-ones-minus-1), (0, 4), (1, −4)
  - Channels 2 and 3 stay 0.
- Wrap, WIDTH=8, STAGES=1, decim_i=0, 129 ones:
  - 127th output = 0x7F, 128th = 0x80, 129th = 0x81
  - No error flag.
- clr_i asserted after 2 of 4 samples (decim_i=3), together with an en_i:
  - That sample is ignored and valid_o stays 0.
  - The next output needs 4 fresh samples and equals 4 (STAGES=1).
- rst_i asserted while valid_o=1:
  - Next cycle valid_o=0, sel_o=0, data_o=0.
  - All counters restart.
  - Lowering decim_i from 7 to 1 while cnt=5 fires on the next sample.
